// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg: shared constants for the AHB-to-APB bridge arbiter.
//   HTRANS_* : AHB transfer type encodings
//   arb_state_t : arbiter FSM states (ARB_IDLE = no owner, ARB_OWN = one owner)
//   AHB_ARB_NUM_M : default number of masters
package ahb_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam int unsigned AHB_ARB_NUM_M = 2;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ahb_arb_pick.sv
// ahb_arb_pick: combinational request picker.
//   i_req   : request vector, one bit per master
//   i_ptr   : index where the search starts (0 gives fixed lowest-index priority)
//   o_grant : one-hot winner, all zero when nothing is requested
module ahb_arb_pick
    import ahb_arb_pkg::*;
#(
    parameter int unsigned NUM_M = AHB_ARB_NUM_M
) (
    input  logic [NUM_M-1:0] i_req,
    input  logic [1:0]       i_ptr,
    output logic [NUM_M-1:0] o_grant
);

    logic w_found;

    // Two passes give a circular search: first indices at or above the
    // pointer, then wrap around to the lowest requesting index.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (!w_found && i_req[i] && (i >= 32'(i_ptr))) begin
                o_grant[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (!w_found && i_req[i]) begin
                o_grant[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// ahb_bridge_arbiter: arbitrates NUM_M AHB masters onto one AHB2APB bridge.
//   Hclk, Hreset        : clock, asynchronous active-high reset
//   Hreq_m, Htrans_m,
//   Haddr_m, Hwrite_m,
//   Hwdata_m            : per-master request and bus signals (master i in slice i)
//   Hreadyout           : ready from the bridge; low freezes all arbiter state
//   Hgrant, Hmaster     : registered one-hot grant and address-phase owner
//   Htrans, Haddr,
//   Hwrite, Hwdata      : muxed bus to the bridge (Hwdata follows the data-phase owner)
//   Hreadyin            : Hreadyout passed through to bridge and masters
// Macro AHB_ARB_RR_EN: when defined, round-robin arbitration; otherwise fixed
// priority with the lowest index winning.
module ahb_bridge_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int unsigned NUM_M = AHB_ARB_NUM_M
) (
    input  logic                Hclk,
    input  logic                Hreset,
    input  logic [NUM_M-1:0]    Hreq_m,
    input  logic [2*NUM_M-1:0]  Htrans_m,
    input  logic [32*NUM_M-1:0] Haddr_m,
    input  logic [NUM_M-1:0]    Hwrite_m,
    input  logic [32*NUM_M-1:0] Hwdata_m,
    input  logic                Hreadyout,
    output logic [NUM_M-1:0]    Hgrant,
    output logic [1:0]          Hmaster,
    output logic [1:0]          Htrans,
    output logic [31:0]         Haddr,
    output logic                Hwrite,
    output logic [31:0]         Hwdata,
    output logic                Hreadyin
);

    arb_state_t       r_state, w_state_nxt;
    logic [NUM_M-1:0] r_grant, w_grant_nxt, w_pick;
    logic [1:0]       r_hmaster, w_hmaster_nxt, r_hdmaster, w_pick_idx, w_ptr;
    logic             w_own_req, w_own_granted, w_releasable, w_any_req;
    logic [1:0]       w_own_trans;

    ahb_arb_pick #(.NUM_M(NUM_M)) u_pick (
        .i_req   (Hreq_m),
        .i_ptr   (w_ptr),
        .o_grant (w_pick)
    );

`ifdef AHB_ARB_RR_EN
    logic [1:0] r_ptr;

    // While owned, the pointer always sits one past the owner; holding the
    // owner rewrites the same value, so only a new grant moves it.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            r_ptr <= '0;
        end else if (Hreadyout && (w_state_nxt == ARB_OWN)) begin
            r_ptr <= (w_hmaster_nxt == 2'(NUM_M - 1)) ? 2'd0 : w_hmaster_nxt + 2'd1;
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    // Address-phase mux from Hmaster, data-phase mux from Hdmaster.
    always_comb begin
        w_own_req     = Hreq_m[0];
        w_own_trans   = Htrans_m[1:0];
        w_own_granted = r_grant[0];
        Haddr         = Haddr_m[31:0];
        Hwrite        = Hwrite_m[0];
        Hwdata        = Hwdata_m[31:0];
        w_pick_idx    = '0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (r_hmaster == 2'(i)) begin
                w_own_req     = Hreq_m[i];
                w_own_trans   = Htrans_m[2*i +: 2];
                w_own_granted = r_grant[i];
                Haddr         = Haddr_m[32*i +: 32];
                Hwrite        = Hwrite_m[i];
            end
            if (r_hdmaster == 2'(i)) begin
                Hwdata = Hwdata_m[32*i +: 32];
            end
            if (w_pick[i]) begin
                w_pick_idx = 2'(i);
            end
        end
    end

    assign w_any_req    = |Hreq_m;
    // A burst in progress (BUSY/SEQ) is never split.
    assign w_releasable = !w_own_req &&
                          ((w_own_trans == HTRANS_IDLE) || (w_own_trans == HTRANS_NONSEQ));

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_hmaster_nxt = r_hmaster;
        if (Hreadyout) begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any_req) begin
                        w_state_nxt   = ARB_OWN;
                        w_grant_nxt   = w_pick;
                        w_hmaster_nxt = w_pick_idx;
                    end
                end
                ARB_OWN: begin
                    if (w_releasable) begin
                        if (w_any_req) begin
                            w_state_nxt   = ARB_OWN;
                            w_grant_nxt   = w_pick;
                            w_hmaster_nxt = w_pick_idx;
                        end else begin
                            w_state_nxt = ARB_IDLE;
                            w_grant_nxt = '0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ARB_IDLE;
                    w_grant_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            r_state    <= ARB_IDLE;
            r_grant    <= '0;
            r_hmaster  <= '0;
            r_hdmaster <= '0;
        end else if (Hreadyout) begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_hmaster  <= w_hmaster_nxt;
            r_hdmaster <= r_hmaster;
        end
    end

    assign Hgrant   = r_grant;
    assign Hmaster  = r_hmaster;
    assign Htrans   = w_own_granted ? w_own_trans : HTRANS_IDLE;
    assign Hreadyin = Hreadyout;

endmodule
